// File: rtl/twobit_comparator.sv
// rtl/twobit_comparator.sv - registered unsigned magnitude comparator with saturating outcome counters
module twobit_comparator #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             clr_cnt,
  output logic             out_valid,
  output logic             g,
  output logic             l,
  output logic             e,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic is_gt;
  logic is_lt;
  logic is_eq;

  always_comb begin
    is_gt = (x > y);
    is_lt = (x < y);
    is_eq = (x == y);
  end

  // Result flags only move on an accepted compare, so they hold between bursts.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      g         <= 1'b0;
      l         <= 1'b0;
      e         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        g <= is_gt;
        l <= is_lt;
        e <= is_eq;
      end
    end
  end

  // A clear in the same cycle as a compare drops that compare from the tallies.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      gt_cnt <= '0;
      lt_cnt <= '0;
      eq_cnt <= '0;
    end else if (in_valid) begin
      if (is_gt && gt_cnt != CNT_MAX) gt_cnt <= gt_cnt + CNT_ONE;
      if (is_lt && lt_cnt != CNT_MAX) lt_cnt <= lt_cnt + CNT_ONE;
      if (is_eq && eq_cnt != CNT_MAX) eq_cnt <= eq_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_twobit_comparator.sv
// tb/tb_twobit_comparator.sv - directed-vector bench for twobit_comparator
module tb_twobit_comparator;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] x;
  logic [1:0] y;
  logic       clr_cnt;

  logic       out_valid, g, l, e;
  logic [7:0] gt_cnt, lt_cnt, eq_cnt;
  logic       s_out_valid, s_g, s_l, s_e;
  logic [1:0] s_gt_cnt, s_lt_cnt, s_eq_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  twobit_comparator dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .clr_cnt(clr_cnt),
    .out_valid(out_valid), .g(g), .l(l), .e(e),
    .gt_cnt(gt_cnt), .lt_cnt(lt_cnt), .eq_cnt(eq_cnt)
  );

  twobit_comparator #(.WIDTH(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .clr_cnt(clr_cnt),
    .out_valid(s_out_valid), .g(s_g), .l(s_l), .e(s_e),
    .gt_cnt(s_gt_cnt), .lt_cnt(s_lt_cnt), .eq_cnt(s_eq_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic [1:0] xx,
                      input logic [1:0] yy, input logic clr);
    rst = r; in_valid = iv; x = xx; y = yy; clr_cnt = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [7:0] gt, input logic [7:0] lt,
                           input logic [7:0] eq);
    check({tag, "_gt"}, 32'(gt_cnt), 32'(gt));
    check({tag, "_lt"}, 32'(lt_cnt), 32'(lt));
    check({tag, "_eq"}, 32'(eq_cnt), 32'(eq));
  endtask

  // x, y, expected {g,l,e}
  logic [1:0] vx  [6] = '{2'b00, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
  logic [1:0] vy  [6] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11, 2'b01};
  logic [2:0] vge [6] = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    // reset
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_gle", 32'({g, l, e}), 0);
    check_cnt("rst_cnt", 0, 0, 0);

    // directed vectors, back to back
    for (int i = 0; i < 6; i++) begin
      step(0, 1, vx[i], vy[i], 0);
      check($sformatf("dir%0d_valid", i), 32'(out_valid), 1);
      check($sformatf("dir%0d_gle", i), 32'({g, l, e}), 32'(vge[i]));
    end
    check_cnt("dir_cnt", 2, 2, 2);

    // idle: hold flags, ignore operands
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 2'(i), 2'(3 - i), 0);
      check($sformatf("idle%0d_valid", i), 32'(out_valid), 0);
      check($sformatf("idle%0d_gle", i), 32'({g, l, e}), 32'(3'b100));
    end
    check_cnt("idle_cnt", 2, 2, 2);

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'd3, 2'd0, 0);
      check($sformatf("sat%0d_s_gt", i), 32'(s_gt_cnt), 3);
      check($sformatf("sat%0d_gt", i), 32'(gt_cnt), 32'(3 + i));
    end
    check("sat_s_lt", 32'(s_lt_cnt), 2);
    check("sat_s_eq", 32'(s_eq_cnt), 2);

    // clear wins over a same-cycle compare
    step(0, 1, 2'd1, 2'd2, 1);
    check_cnt("clr_cnt", 0, 0, 0);
    check("clr_s_gt", 32'(s_gt_cnt), 0);
    check("clr_gle", 32'({g, l, e}), 32'(3'b010));
    check("clr_valid", 32'(out_valid), 1);

    step(0, 1, 2'd2, 2'd2, 0);
    check_cnt("post_clr_cnt", 0, 0, 1);

    // reset mid-stream
    step(1, 1, 2'd3, 2'd1, 0);
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_gle", 32'({g, l, e}), 0);
    check_cnt("mrst_cnt", 0, 0, 0);

    // exhaustive sweep
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        logic [2:0] exp_gle;
        exp_gle = (a > b) ? 3'b100 : (a < b) ? 3'b010 : 3'b001;
        step(0, 1, 2'(a), 2'(b), 0);
        check($sformatf("sw%0d%0d_gle", a, b), 32'({g, l, e}), 32'(exp_gle));
        check($sformatf("sw%0d%0d_onehot", a, b), 32'($countones({g, l, e})), 1);
      end
    end
    step(0, 0, 0, 0, 0);
    check_cnt("sw_cnt", 6, 6, 4);
    check("sw_s_gt", 32'(s_gt_cnt), 3);
    check("sw_s_lt", 32'(s_lt_cnt), 3);
    check("sw_s_eq", 32'(s_eq_cnt), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
